// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and sizing helpers for the systolic sequencer
//
// Purpose: single source for the sequencer FSM encoding and the derived
// step-count constants, so the top and the skew selectors agree on widths.
// Ports: none (package).

package seq_pkg;

    // Sequencer phases, in the order a run walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Default geometry of the 4x4 array this sequencer was built for.
    localparam int N_DEFAULT     = 4;
    localparam int DRAIN_DEFAULT = 4;

    // A wavefront needs 2N-1 feed steps for the last skewed element to enter.
    localparam int FEED_STEPS = 2 * N_DEFAULT - 1;

    // CLEAR + FEED + DRAIN + DONE for the default geometry.
    localparam int TOTAL_BUSY = 1 + FEED_STEPS + DRAIN_DEFAULT + 1;

    function automatic int feed_steps(input int n);
        return 2 * n - 1;
    endfunction

    // Wide enough to hold every step index of a run with one spare bit,
    // so the counter can never wrap before the phase comparison fires.
    function automatic int step_width(input int n, input int drain);
        return $clog2(2 * n - 1 + drain) + 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_mux.sv
// rtl/systolic_seq_ctrl_skew_mux.sv - selects one skewed edge element of a matrix for a feed step
//
// Purpose: for feed step t and edge index e, returns
//   row mode (COL_MODE=0): mat[e][t-e]   (left edge, row e of A)
//   col mode (COL_MODE=1): mat[t-e][e]   (top edge, column e of B)
// or 0 when t-e falls outside 0..N-1.
// Ports:
//   step_i   current feed step t
//   edge_i   row (left edge) or column (top edge) index e
//   mat_i    full operand matrix, mat_i[row][col]
//   slice_o  selected element, 0 outside the wavefront

module skew_mux
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter int IDX_W      = (N > 1) ? $clog2(N) : 1,
    parameter int STEP_W     = step_width(N, DRAIN_DEFAULT),
    parameter bit COL_MODE   = 1'b0
) (
    input  logic [STEP_W-1:0]                     step_i,
    input  logic [IDX_W-1:0]                      edge_i,
    input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   mat_i,
    output logic [DATA_WIDTH-1:0]                 slice_o
);

    // Instead of forming t-e (which would wrap for t<e), look for the k with
    // t == e + k. At most one k matches; no match means the slot is empty.
    always_comb begin
        slice_o = '0;
        for (int k = 0; k < N; k++) begin
            if (step_i == (STEP_W'(edge_i) + STEP_W'(k))) begin
                if (COL_MODE) begin
                    slice_o = mat_i[k][edge_i];
                end else begin
                    slice_o = mat_i[edge_i][k];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - run sequencer feeding skewed operands into an NxN systolic array
//
// Purpose: holds operand matrices A and B, and on start clears the array,
// streams skewed A rows into the left edge and skewed B columns into the top
// edge, waits for the wavefront to drain, then pulses done.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   wr_en_i/wr_sel_i       operand write strobe, 0 = A, 1 = B
//   wr_row_i/wr_col_i      element position
//   wr_data_i              element value
//   start_i                run request, sampled only while idle
//   busy_o                 run in progress (CLEAR..DONE)
//   done_o                 one-cycle completion pulse
//   wr_err_o               one-cycle pulse after a write attempted while busy
//   array_rst_no           active-low clear to the PE array
//   left_o / up_o          packed edge feeds, slice r / c per row / column

module systolic_seq_ctrl
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic                      wr_sel_i,
    input  logic [$clog2(N)-1:0]      wr_row_i,
    input  logic [$clog2(N)-1:0]      wr_col_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      wr_err_o,
    output logic                      array_rst_no,
    output logic [N*DATA_WIDTH-1:0]   left_o,
    output logic [N*DATA_WIDTH-1:0]   up_o
);

    localparam int IDX_W  = $clog2(N);
    localparam int STEPS  = feed_steps(N);
    localparam int STEP_W = step_width(N, DRAIN_CYCLES);

    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;
    typedef logic [N-1:0][DATA_WIDTH-1:0]        edge_t;

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    mat_t              mat_a_q, mat_a_d;
    mat_t              mat_b_q, mat_b_d;

    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              wr_err_q,   wr_err_d;
    logic              arst_n_q,   arst_n_d;
    edge_t             left_q,     left_d;
    edge_t             up_q,       up_d;

    edge_t             left_sel;
    edge_t             up_sel;

    // ------------------------------------------------------------------
    // Phase sequencing. The step counter restarts at 0 on entry to FEED
    // and DRAIN, so it indexes the feed step t directly during FEED.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    step_d  = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                step_d  = '0;
            end
            FEED: begin
                if (step_q == FEED_LAST) begin
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            DRAIN: begin
                if (step_q == DRAIN_LAST) begin
                    state_d = DONE;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand writes. Only committed while idle, so the matrices are stable
    // for the whole run; a write that lands together with start is already
    // in the register file when the first feed step is formed.
    // ------------------------------------------------------------------
    always_comb begin
        mat_a_d  = mat_a_q;
        mat_b_d  = mat_b_q;
        wr_err_d = 1'b0;
        if (wr_en_i) begin
            if (state_q == IDLE) begin
                if (wr_sel_i) begin
                    mat_b_d[wr_row_i][wr_col_i] = wr_data_i;
                end else begin
                    mat_a_d[wr_row_i][wr_col_i] = wr_data_i;
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge selectors. They look at the next step and the committed
    // matrices so the registered edge outputs line up with the registered
    // state: the value for step t is on the pins while FEED step t is shown.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_edge
        skew_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .IDX_W      (IDX_W),
            .STEP_W     (STEP_W),
            .COL_MODE   (1'b0)
        ) u_left (
            .step_i  (step_d),
            .edge_i  (IDX_W'(g)),
            .mat_i   (mat_a_q),
            .slice_o (left_sel[g])
        );

        skew_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .IDX_W      (IDX_W),
            .STEP_W     (STEP_W),
            .COL_MODE   (1'b1)
        ) u_up (
            .step_i  (step_d),
            .edge_i  (IDX_W'(g)),
            .mat_i   (mat_b_q),
            .slice_o (up_sel[g])
        );
    end

    // Outputs are decoded from the next state and registered, so every pin
    // changes exactly at the edge where the phase changes.
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        // The array is held in clear while idle and during CLEAR; DONE keeps
        // it released so the host can still read the accumulated results.
        arst_n_d = (state_d == FEED) || (state_d == DRAIN) || (state_d == DONE);
        left_d   = (state_d == FEED) ? left_sel : '0;
        up_d     = (state_d == FEED) ? up_sel   : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            step_q   <= '0;
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            arst_n_q <= 1'b0;
            left_q   <= '0;
            up_q     <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            mat_a_q  <= mat_a_d;
            mat_b_q  <= mat_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            arst_n_q <= arst_n_d;
            left_q   <= left_d;
            up_q     <= up_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign wr_err_o     = wr_err_q;
    assign array_rst_no = arst_n_q;
    assign left_o       = left_q;
    assign up_o         = up_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed vector bench for the systolic run sequencer

module tb_systolic_seq_ctrl;

    localparam int DW = 32;
    localparam int NN = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic           wr_sel;
    logic [1:0]     wr_row;
    logic [1:0]     wr_col;
    logic [DW-1:0]  wr_data;
    logic           start;
    logic           busy;
    logic           done;
    logic           wr_err;
    logic           arst_n;
    logic [127:0]   left;
    logic [127:0]   up;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .DATA_WIDTH   (DW),
        .N            (NN),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_sel_i     (wr_sel),
        .wr_row_i     (wr_row),
        .wr_col_i     (wr_col),
        .wr_data_i    (wr_data),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .wr_err_o     (wr_err),
        .array_rst_no (arst_n),
        .left_o       (left),
        .up_o         (up)
    );

    typedef struct {
        logic         busy;
        logic         done;
        logic         arstn;
        logic [127:0] left;
        logic [127:0] up;
    } vec_t;

    vec_t tbl [14];

    int nvec = 0;
    int nerr = 0;

    function automatic logic [127:0] pk(input int e3, input int e2, input int e1, input int e0);
        return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
    endfunction

    task automatic chk(input string name, input logic [258:0] act, input logic [258:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int row, input int col, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(row);
        wr_col  = 2'(col);
        wr_data = 32'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    int            dcount;
    logic [255:0]  acc;

    initial begin
        // Offsets j count edges after the start edge: 0 CLEAR, 1..7 FEED
        // t=0..6, 8..11 DRAIN, 12 DONE, 13 IDLE. A[i][j]=4i+j+1, B=identity.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, pk(0, 0, 0, 1),     pk(0, 0, 0, 1)};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, pk(0, 0, 5, 2),     pk(0, 0, 0, 0)};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, pk(0, 9, 6, 3),     pk(0, 0, 1, 0)};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, pk(13, 10, 7, 4),   pk(0, 0, 0, 0)};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, pk(14, 11, 8, 0),   pk(0, 1, 0, 0)};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, pk(15, 12, 0, 0),   pk(0, 0, 0, 0)};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, pk(16, 0, 0, 0),    pk(1, 0, 0, 0)};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[10] = '{1'b1, 1'b0, 1'b1, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[11] = '{1'b1, 1'b0, 1'b1, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[12] = '{1'b1, 1'b1, 1'b1, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
        tbl[13] = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", {busy, done, arst_n, left, up}, '0);
        chk("reset_wr_err", 259'(wr_err), '0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", {busy, done, arst_n, left, up}, '0);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                wr(1'b0, i, j, 4 * i + j + 1);
                wr(1'b1, i, j, (i == j) ? 1 : 0);
            end
        end
        tick();
        chk("idle_write_no_err", 259'(wr_err), '0);

        // Main run, one table vector per cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 14; j++) begin
            chk($sformatf("vec_off%0d", j), {busy, done, arst_n, left, up},
                {tbl[j].busy, tbl[j].done, tbl[j].arstn, tbl[j].left, tbl[j].up});
            tick();
        end

        // Write attempted during FEED is dropped and flagged.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd99;
        tick();
        wr_en = 1'b0;
        chk("busy_wr_err_pulse", 259'(wr_err), 259'(1));
        tick();
        chk("busy_wr_err_clears", 259'(wr_err), '0);
        repeat (9) tick();
        chk("busy_wr_back_idle", 259'(busy), '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("readback_a00", 259'(left), 259'(pk(0, 0, 0, 1)));
        repeat (13) tick();

        // start held high: runs back to back with one idle cycle between.
        start = 1'b1;
        tick();
        dcount = 0;
        for (int j = 0; j < 28; j++) begin
            if (done) dcount++;
            if (j == 12) chk("b2b_done1", 259'({busy, done}), 259'(2'b11));
            if (j == 13) chk("b2b_idle_gap", 259'({busy, arst_n}), '0);
            if (j == 14) chk("b2b_clear2", 259'({busy, arst_n, left}), 259'({1'b1, 1'b0, 128'd0}));
            if (j == 26) chk("b2b_done2", 259'({busy, done}), 259'(2'b11));
            if (j == 27) start = 1'b0;
            tick();
        end
        chk("b2b_done_count", 259'(dcount), 259'(2));
        chk("b2b_no_third_run", 259'(busy), '0);
        tick();

        // Reset at FEED t=3 aborts and clears the matrices.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_abort_t3", 259'(left), 259'(pk(13, 10, 7, 4)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outputs", {busy, done, arst_n, left, up}, '0);
        dcount = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (done) dcount++;
        end
        chk("abort_no_done", 259'(dcount), '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = '0;
        for (int j = 0; j < 7; j++) begin
            tick();
            acc = acc | {left, up};
        end
        chk("abort_mats_zero", 259'(acc), '0);
        chk("abort_run_busy", 259'({busy, arst_n}), 259'(2'b11));
        repeat (8) tick();

        // Write together with start is used by that run.
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd3; wr_col = 2'd3; wr_data = 32'd77;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        chk("same_cycle_wr_no_err", 259'(wr_err), '0);
        repeat (7) tick();
        chk("same_cycle_wr_t6", {busy, done, arst_n, left, up},
            {1'b1, 1'b0, 1'b1, pk(77, 0, 0, 0), pk(0, 0, 0, 0)});
        repeat (8) tick();
        chk("final_idle", 259'({busy, done, arst_n}), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
